iq_mux_ps: RTL and testbench

//  Parallel->serial I/Q interleaver feeding the DDC serial->parallel demux stage.

---
 rtl/iq_mux_ps_pkg.sv | 29 ++
 rtl/iq_mux_ps_if.sv | 32 +++
 rtl/iq_mux_ps_fifo.sv | 69 ++++++
 rtl/iq_mux_ps.sv | 195 +++++++++++++++++++
 tb/tb_iq_mux_ps.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_mux_ps_pkg.sv
// rtl/iq_mux_ps_pkg.sv - shared constants, FSM states and helpers for the I/Q interleaver
// Package iq_mux_pkg:
//   CHIDX_I / CHIDX_Q : channel tags carried on Data_Out_ChIdx
//   state_t           : slot sequencer states (IDLE, SLOT_I, SLOT_Q)
//   DROP_CNT_W        : width of the optional dropped-sample counter
//   sat_add_drop      : saturating add used by the dropped-sample counter
package iq_mux_pkg;

    localparam logic [3:0] CHIDX_I    = 4'd0;
    localparam logic [3:0] CHIDX_Q    = 4'd1;
    localparam int         DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_I = 2'd1,
        SLOT_Q = 2'd2
    } state_t;

    // Adds 0..2 dropped samples, pinning at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
        input logic [DROP_CNT_W-1:0] a,
        input logic [1:0]            n
    );
        logic [DROP_CNT_W:0] s;
        s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, n};
        return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/iq_mux_ps_if.sv
// rtl/iq_mux_ps_if.sv - stream/status bundle between a sample source and the I/Q interleaver
// Signals:
//   Data_In_I/_Valid, Data_In_Q/_Valid : parallel I and Q sample strobes
//   Ovf_Clr                            : clears the sticky overflow flags
//   Data_Out, Data_Out_ChIdx           : serial sample and its channel tag
//   Data_Out_Valid                     : sample-valid window inside each slot
//   Ovf_I, Ovf_Q                       : sticky dropped-sample flags
// Modports: master drives the inputs of the interleaver, slave is the interleaver.
interface iq_mux_ps_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] Data_In_I;
    logic                  Data_In_I_Valid;
    logic [DATA_WIDTH-1:0] Data_In_Q;
    logic                  Data_In_Q_Valid;
    logic                  Ovf_Clr;
    logic [DATA_WIDTH-1:0] Data_Out;
    logic [3:0]            Data_Out_ChIdx;
    logic                  Data_Out_Valid;
    logic                  Ovf_I;
    logic                  Ovf_Q;

    modport master (
        output Data_In_I, Data_In_I_Valid, Data_In_Q, Data_In_Q_Valid, Ovf_Clr,
        input  Data_Out, Data_Out_ChIdx, Data_Out_Valid, Ovf_I, Ovf_Q
    );

    modport slave (
        input  Data_In_I, Data_In_I_Valid, Data_In_Q, Data_In_Q_Valid, Ovf_Clr,
        output Data_Out, Data_Out_ChIdx, Data_Out_Valid, Ovf_I, Ovf_Q
    );
endinterface

// File: rtl/iq_mux_ps_fifo.sv
// rtl/iq_mux_ps_fifo.sv - synchronous first-word-fall-through sample FIFO (module iq_ps_fifo)
// Ports:
//   clk, nrst  : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, din : write strobe and data; accepted when not full, or full with a read
//   rd_en      : pop the head entry (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   empty/full : occupancy flags
//   count      : occupancy, 0..FIFO_DEPTH
module iq_ps_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  w_do_rd;
    logic                  w_do_wr;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_FULL);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A write into a full FIFO is still taken when the head leaves in the
    // same cycle: the freed slot is exactly the one being written.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/iq_mux_ps.sv
// rtl/iq_mux_ps.sv - parallel-to-serial I/Q interleaver with fixed-length output slots
// Buffers I and Q samples in two FIFOs and emits complete pairs as I slot then
// Q slot, each SLOT_CLKS clocks long, with Data_Out_Valid high on slot cycles
// 1..VALID_CLKS so data/tag are stable around the valid window.
// Ports:
//   CLK, nRST : clock, synchronous active-low reset
//   Drop_Cnt  : saturating count of dropped I+Q samples (only with IQ_MUX_PS_DROP_CNT_EN)
//   bus       : iq_mux_ps_if.slave - sample inputs, serial output, overflow flags
// Build option: define IQ_MUX_PS_DROP_CNT_EN to add the Drop_Cnt output.
module iq_mux_ps
    import iq_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int SLOT_CLKS  = 8,
    parameter int VALID_CLKS = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
`ifdef IQ_MUX_PS_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] Drop_Cnt,
`endif
    iq_mux_ps_if.slave            bus
);
    localparam int                    CNT_W     = $clog2(SLOT_CLKS);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SLOT_CLKS - 1);
    localparam logic [CNT_W-1:0]      CNT_VLAST = CNT_W'(VALID_CLKS);
    localparam int                    LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] w_i_dout;
    logic [DATA_WIDTH-1:0] w_q_dout;
    logic                  w_i_empty;
    logic                  w_q_empty;
    logic                  w_i_full;
    logic                  w_q_full;
    logic [LVL_W-1:0]      w_i_count;
    logic [LVL_W-1:0]      w_q_count;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_hold_q;
    logic [3:0]            r_chidx;
    logic                  r_valid;
    logic                  r_ovf_i;
    logic                  r_ovf_q;

    logic                  w_pair_rdy;
    logic                  w_slot_end;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_drop_i;
    logic                  w_drop_q;

    // Only whole pairs leave the FIFOs; a pop happens from IDLE or at the
    // last cycle of the Q slot so consecutive pairs run without a gap.
    assign w_pair_rdy = !w_i_empty && !w_q_empty;
    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_pop      = w_pair_rdy && ((r_state == IDLE) || ((r_state == SLOT_Q) && w_slot_end));
    assign w_cnt_next = r_cnt + 1'b1;

    assign w_drop_i = bus.Data_In_I_Valid && w_i_full && !w_pop;
    assign w_drop_q = bus.Data_In_Q_Valid && w_q_full && !w_pop;

    iq_ps_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_i (
        .clk   (CLK),
        .nrst  (nRST),
        .wr_en (bus.Data_In_I_Valid),
        .din   (bus.Data_In_I),
        .rd_en (w_pop),
        .dout  (w_i_dout),
        .empty (w_i_empty),
        .full  (w_i_full),
        .count (w_i_count)
    );

    iq_ps_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_q (
        .clk   (CLK),
        .nrst  (nRST),
        .wr_en (bus.Data_In_Q_Valid),
        .din   (bus.Data_In_Q),
        .rd_en (w_pop),
        .dout  (w_q_dout),
        .empty (w_q_empty),
        .full  (w_q_full),
        .count (w_q_count)
    );

    // r_data_out doubles as the I hold register; only Q needs its own copy.
    // Valid is registered from the next counter value so it lines up with
    // the slot position it describes.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_hold_q   <= '0;
            r_chidx    <= CHIDX_I;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state    <= SLOT_I;
                        r_cnt      <= '0;
                        r_data_out <= w_i_dout;
                        r_hold_q   <= w_q_dout;
                        r_chidx    <= CHIDX_I;
                    end
                end
                SLOT_I: begin
                    if (w_slot_end) begin
                        r_state    <= SLOT_Q;
                        r_cnt      <= '0;
                        r_data_out <= r_hold_q;
                        r_chidx    <= CHIDX_Q;
                    end else begin
                        r_cnt   <= w_cnt_next;
                        r_valid <= (w_cnt_next <= CNT_VLAST);
                    end
                end
                SLOT_Q: begin
                    if (w_slot_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_state    <= SLOT_I;
                            r_data_out <= w_i_dout;
                            r_hold_q   <= w_q_dout;
                            r_chidx    <= CHIDX_I;
                        end else begin
                            // Data and tag keep their last values while idle.
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt   <= w_cnt_next;
                        r_valid <= (w_cnt_next <= CNT_VLAST);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, so no drop goes unflagged.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ovf_i <= 1'b0;
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_i <= (r_ovf_i && !bus.Ovf_Clr) || w_drop_i;
            r_ovf_q <= (r_ovf_q && !bus.Ovf_Clr) || w_drop_q;
        end
    end

`ifdef IQ_MUX_PS_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [1:0]            w_n_drop;

    assign w_n_drop = {1'b0, w_drop_i} + {1'b0, w_drop_q};

    // Clear restarts the count from this cycle's drops.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= sat_add_drop(bus.Ovf_Clr ? '0 : r_drop_cnt, w_n_drop);
        end
    end

    assign Drop_Cnt = r_drop_cnt;
`endif

    assign bus.Data_Out       = r_data_out;
    assign bus.Data_Out_ChIdx = r_chidx;
    assign bus.Data_Out_Valid = r_valid;
    assign bus.Ovf_I          = r_ovf_i;
    assign bus.Ovf_Q          = r_ovf_q;

    // FIFO flags must agree with the occupancy counts.
    a_fifo_flags: assert property (@(posedge CLK) disable iff (!nRST)
        (w_i_empty == (w_i_count == '0)) && (w_q_empty == (w_q_count == '0)) &&
        (w_i_full == (w_i_count == LVL_FULL)) && (w_q_full == (w_q_count == LVL_FULL)));

endmodule

// File: tb/tb_iq_mux_ps.sv
// tb/tb_iq_mux_ps.sv - scoreboard bench for iq_mux_ps
module tb_iq_mux_ps;
    import iq_mux_pkg::*;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int SLOT  = 8;
    localparam int VCLK  = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    iq_mux_ps_if #(.DATA_WIDTH(DW)) bus ();
`ifdef IQ_MUX_PS_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    iq_mux_ps #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SLOT_CLKS  (SLOT),
        .VALID_CLKS (VCLK)
    ) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
`ifdef IQ_MUX_PS_DROP_CNT_EN
        .Drop_Cnt (drop_cnt),
`endif
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;

    // Reference model: unpaired I and Q samples, and the expected serial words {tag, data}.
    logic [DW-1:0] mi[$];
    logic [DW-1:0] mq[$];
    logic [27:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic void model_pair();
        while (mi.size() > 0 && mq.size() > 0) begin
            exp_q.push_back({CHIDX_I, mi.pop_front()});
            exp_q.push_back({CHIDX_Q, mq.pop_front()});
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit do_i, input logic [DW-1:0] di,
                         input bit do_q, input logic [DW-1:0] dq, input bit drop_i);
        bus.Data_In_I       = di;
        bus.Data_In_I_Valid = do_i;
        bus.Data_In_Q       = dq;
        bus.Data_In_Q_Valid = do_q;
        tick();
        bus.Data_In_I_Valid = 1'b0;
        bus.Data_In_Q_Valid = 1'b0;
        if (do_i && !drop_i) mi.push_back(di);
        if (do_q) mq.push_back(dq);
        model_pair();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        exp_q.delete();
        mi.delete();
        mq.delete();
        repeat (2) tick();
        nRST = 1'b1;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        check(tag, exp_q.size(), 0);
        repeat (2 * SLOT) tick();
    endtask

    // Cycle-exact slot pattern: the first pair pops two cycles after its strobe
    // cycle, then slots of SLOT clocks alternate I/Q with valid on positions 1..VCLK.
    task automatic check_slots(input string tag, input int kstart, input int nslots,
                               input logic [DW-1:0] vals [8]);
        int   falls = 0;
        logic pv    = 1'b0;
        for (int k = kstart; k <= 2 + nslots * SLOT; k++) begin
            logic          ev;
            logic [3:0]    ech;
            logic [DW-1:0] ed;
            tick();
            if (k < 2 + nslots * SLOT) begin
                ev  = ((k - 2) % SLOT >= 1) && ((k - 2) % SLOT <= VCLK);
                ech = 4'(((k - 2) / SLOT) % 2);
                ed  = vals[(k - 2) / SLOT];
            end else begin
                ev  = 1'b0;
                ech = 4'((nslots - 1) % 2);
                ed  = vals[nslots - 1];
            end
            check(tag, {bus.Data_Out_Valid, bus.Data_Out_ChIdx, bus.Data_Out}, {ev, ech, ed});
            if (pv && !bus.Data_Out_Valid) falls++;
            pv = bus.Data_Out_Valid;
        end
        check({tag, "_pulses"}, falls, nslots);
    endtask

    // Monitor: on every rising valid, pop the scoreboard and compare; also checks
    // pulse width and that data/tag are stable one clock before and after the pulse.
    initial begin
        logic        in_pulse = 1'b0;
        int          plen = 0;
        logic [27:0] prev_word = '0;
        logic [27:0] rise_word = '0;
        logic [27:0] cur;
        forever begin
            @(negedge CLK);
            cur = {bus.Data_Out_ChIdx, bus.Data_Out};
            if (!nRST) begin
                in_pulse = 1'b0;
            end else if (bus.Data_Out_Valid && !in_pulse) begin
                in_pulse = 1'b1;
                plen     = 1;
                n_pulses++;
                rise_word = cur;
                check("setup_stable", cur, prev_word);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_valid: actual word %0h required no output", cur);
                end else begin
                    check("sb_word", cur, exp_q.pop_front());
                end
            end else if (bus.Data_Out_Valid) begin
                plen++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check("valid_len", plen, VCLK);
                check("hold_stable", cur, rise_word);
            end
            prev_word = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sv [8];
        logic [DW-1:0] v;
        int p0;
        int mode;

        bus.Data_In_I = '0;
        bus.Data_In_I_Valid = 1'b0;
        bus.Data_In_Q = '0;
        bus.Data_In_Q_Valid = 1'b0;
        bus.Ovf_Clr = 1'b0;
        for (int i = 0; i < 8; i++) sv[i] = '0;

        do_reset();
        check("reset_out", {bus.Data_Out_Valid, bus.Data_Out_ChIdx, bus.Data_Out}, 29'd0);
        check("reset_ovf", {bus.Ovf_I, bus.Ovf_Q}, 2'b00);

        // Single pair with exact latency and slot timing.
        sv[0] = 24'h000123;
        sv[1] = 24'hFFFF00;
        drive(1'b1, sv[0], 1'b1, sv[1], 1'b0);
        check_slots("single_pair", 2, 2, sv);

        // Lone I samples wait for a Q partner.
        p0 = n_pulses;
        drive(1'b1, 24'hA00001, 1'b0, '0, 1'b0);
        drive(1'b1, 24'hA00002, 1'b0, '0, 1'b0);
        drive(1'b1, 24'hA00003, 1'b0, '0, 1'b0);
        repeat (40) tick();
        check("lone_i_no_valid", n_pulses - p0, 0);
        drive(1'b0, '0, 1'b1, 24'hB00001, 1'b0);
        repeat (40) tick();
        check("lone_i_one_pair", n_pulses - p0, 2);
        drive(1'b0, '0, 1'b1, 24'hB00002, 1'b0);
        drive(1'b0, '0, 1'b1, 24'hB00003, 1'b0);
        drain("lone_i_rest");
        check("lone_i_rest_pulses", n_pulses - p0, 6);

        // Overflow of the I FIFO with no Q present.
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        check("ovf_i_at_full", bus.Ovf_I, 1'b0);
        drive(1'b1, 24'hDEAD01, 1'b0, '0, 1'b1);
        check("ovf_i_set", bus.Ovf_I, 1'b1);
        check("ovf_q_clear", bus.Ovf_Q, 1'b0);
`ifdef IQ_MUX_PS_DROP_CNT_EN
        check("drop_cnt_1", drop_cnt, 16'd1);
`endif
        tick();
        check("ovf_i_sticky", bus.Ovf_I, 1'b1);
        bus.Ovf_Clr = 1'b1;
        tick();
        bus.Ovf_Clr = 1'b0;
        check("ovf_i_cleared", bus.Ovf_I, 1'b0);
`ifdef IQ_MUX_PS_DROP_CNT_EN
        check("drop_cnt_clr", drop_cnt, 16'd0);
`endif

        // Full I FIFO: a write coinciding with the IDLE pop is accepted.
        drive(1'b0, '0, 1'b1, 24'hC00000, 1'b0);
        drive(1'b1, 24'hE0E0E0, 1'b0, '0, 1'b0);
        check("full_pop_no_ovf", bus.Ovf_I, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, DW'(24'hC00001 + i), 1'b0);
        drain("full_pop_drain");
        check("full_pop_ovf_end", {bus.Ovf_I, bus.Ovf_Q}, 2'b00);

        // Back-to-back pairs with no idle cycle between them.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            sv[2*p]   = DW'($urandom);
            sv[2*p+1] = DW'($urandom);
            drive(1'b1, sv[2*p], 1'b1, sv[2*p+1], 1'b0);
        end
        check_slots("b2b", 5, 8, sv);

        // Randomised traffic against the pairing model.
        for (int it = 0; it < 60; it++) begin
            int w = 0;
            while (mi.size() + mq.size() + exp_q.size() > 8 && w < 500) begin
                tick();
                w++;
            end
            mode = int'($urandom_range(0, 2));
            if (mode == 1 && mi.size() >= 4) mode = 0;
            if (mode == 2 && mq.size() >= 4) mode = 0;
            v = DW'($urandom);
            drive(mode != 2, v, mode != 1, DW'($urandom), 1'b0);
            repeat ($urandom_range(0, 10)) tick();
        end
        drain("random_drain");
        check("random_ovf", {bus.Ovf_I, bus.Ovf_Q}, 2'b00);

        // Reset in the middle of a Q slot aborts it and discards the queued pair.
        do_reset();
        drive(1'b1, 24'h111111, 1'b1, 24'h222222, 1'b0);
        drive(1'b1, 24'h333333, 1'b1, 24'h444444, 1'b0);
        repeat (11) tick();
        check("pre_reset_slot_q", {bus.Data_Out_Valid, bus.Data_Out_ChIdx, bus.Data_Out},
              {1'b1, CHIDX_Q, 24'h222222});
        nRST = 1'b0;
        exp_q.delete();
        mi.delete();
        mq.delete();
        tick();
        check("mid_reset_out", {bus.Data_Out_Valid, bus.Data_Out_ChIdx, bus.Data_Out}, 29'd0);
        check("mid_reset_ovf", {bus.Ovf_I, bus.Ovf_Q}, 2'b00);
        nRST = 1'b1;
        p0 = n_pulses;
        repeat (60) tick();
        check("post_reset_quiet", n_pulses - p0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
